// File: rtl/safe_clk_freq_monitor_if.sv
// Control/status bundle between the safety clock frequency monitor and its consumer.
// st_force_i exists only when SAFE_CLK_MON_SELFTEST_EN is defined.
interface safe_clk_freq_monitor_if #(
    parameter int CNT_W = 16
);
    logic             enable_i;
    logic             fault_clr_i;
`ifdef SAFE_CLK_MON_SELFTEST_EN
    logic [1:0]       st_force_i;
`endif
    logic             clk_ok_o;
    logic             clk_fault_o;
    logic [1:0]       fault_code_o;
    logic [CNT_W-1:0] edge_cnt_o;
    logic             cnt_valid_o;

`ifdef SAFE_CLK_MON_SELFTEST_EN
    modport master (output enable_i, fault_clr_i, st_force_i,
                    input  clk_ok_o, clk_fault_o, fault_code_o, edge_cnt_o, cnt_valid_o);
    modport slave  (input  enable_i, fault_clr_i, st_force_i,
                    output clk_ok_o, clk_fault_o, fault_code_o, edge_cnt_o, cnt_valid_o);
`else
    modport master (output enable_i, fault_clr_i,
                    input  clk_ok_o, clk_fault_o, fault_code_o, edge_cnt_o, cnt_valid_o);
    modport slave  (input  enable_i, fault_clr_i,
                    output clk_ok_o, clk_fault_o, fault_code_o, edge_cnt_o, cnt_valid_o);
`endif
endinterface

// File: rtl/safe_clk_freq_monitor.sv
// Windowed frequency checker for the safety-island clock with acquire/lock FSM and sticky fault.
// Optional self-test count forcing is enabled by defining SAFE_CLK_MON_SELFTEST_EN.
module safe_clk_freq_monitor #(
    parameter int WIN_CYCLES  = 1024,
    parameter int CNT_W       = 16,
    parameter int EXP_MIN     = 240,
    parameter int EXP_MAX     = 272,
    parameter int LOCK_WINS   = 4,
    parameter int FAIL_WINS   = 2,
    parameter int ACQ_TIMEOUT = 16
) (
    input  logic                    clk_main_i,
    input  logic                    rst_n_main_i,
    input  logic                    clk_safety_i,
    input  logic                    rst_n_safety_i,
    safe_clk_freq_monitor_if.slave  bus
);
    localparam int WIN_W  = $clog2(WIN_CYCLES);
    localparam int GOOD_W = $clog2(LOCK_WINS + 1);
    localparam int FAIL_W = $clog2(FAIL_WINS + 1);
    localparam int ACQ_W  = $clog2(ACQ_TIMEOUT + 1);

    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  MIN_C     = CNT_W'(EXP_MIN);
    localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(EXP_MAX);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_WINS - 1);
    localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(FAIL_WINS - 1);
    localparam logic [ACQ_W-1:0]  ACQ_LAST  = ACQ_W'(ACQ_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCK, S_FAULT} state_t;

    state_t             r_state;
    logic               r_tgl;
    logic [2:0]         r_sync;
    logic [WIN_W-1:0]   r_win;
    logic [CNT_W-1:0]   r_edge;
    logic [GOOD_W-1:0]  r_good;
    logic [FAIL_W-1:0]  r_fail;
    logic [ACQ_W-1:0]   r_acq;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_valid;
    logic               r_ok;
    logic               r_fault;
    logic [1:0]         r_code;

    logic               w_edge;
    logic               w_tc;
    logic               w_clr;
    logic               w_drop;
    logic               w_in;
    logic [1:0]         w_code;
    logic [CNT_W-1:0]   w_cnt_raw;
    logic [CNT_W-1:0]   w_cnt;

    // Toggle flop lets the slow domain be sampled as a level; one change = one safety cycle.
    always_ff @(posedge clk_safety_i or negedge rst_n_safety_i) begin
        if (!rst_n_safety_i) r_tgl <= 1'b0;
        else                 r_tgl <= ~r_tgl;
    end

    always_ff @(posedge clk_main_i or negedge rst_n_main_i) begin
        if (!rst_n_main_i) r_sync <= '0;
        else               r_sync <= {r_sync[1:0], r_tgl};
    end

    assign w_edge    = r_sync[2] ^ r_sync[1];
    assign w_tc      = (r_state != S_IDLE) && (r_win == WIN_LAST);
    assign w_clr     = (r_state == S_FAULT) && bus.fault_clr_i && bus.enable_i;
    assign w_drop    = w_clr || (!bus.enable_i && (r_state == S_ACQ || r_state == S_LOCK));
    assign w_cnt_raw = (r_edge == CNT_MAX) ? r_edge : r_edge + CNT_W'(w_edge);

    always_comb begin
        w_cnt = w_cnt_raw;
`ifdef SAFE_CLK_MON_SELFTEST_EN
        case (bus.st_force_i)
            2'b01:   w_cnt = '0;
            2'b10:   w_cnt = CNT_MAX;
            default: w_cnt = w_cnt_raw;
        endcase
`endif
    end

    assign w_in   = (w_cnt >= MIN_C) && (w_cnt <= MAX_C);
    assign w_code = (w_cnt == '0) ? 2'b11 : (w_cnt < MIN_C) ? 2'b01 : 2'b10;

    always_ff @(posedge clk_main_i or negedge rst_n_main_i) begin
        if (!rst_n_main_i) begin
            r_state <= S_IDLE;
            r_win   <= '0;
            r_edge  <= '0;
            r_good  <= '0;
            r_fail  <= '0;
            r_acq   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_ok    <= 1'b0;
            r_fault <= 1'b0;
            r_code  <= 2'b00;
        end else begin
            r_valid <= 1'b0;
            if (r_state != S_IDLE) begin
                r_win  <= w_tc ? '0 : r_win + 1'b1;
                r_edge <= w_tc ? '0 : w_cnt_raw;
            end
            if (w_tc && !w_drop) begin
                r_cnt   <= w_cnt;
                r_valid <= 1'b1;
            end
            case (r_state)
                S_IDLE: if (bus.enable_i) r_state <= S_ACQ;
                S_ACQ, S_LOCK: begin
                    if (!bus.enable_i) begin
                        r_state <= S_IDLE;
                        r_ok    <= 1'b0;
                        r_win   <= '0;
                        r_edge  <= '0;
                        r_good  <= '0;
                        r_fail  <= '0;
                        r_acq   <= '0;
                    end else if (w_tc && r_state == S_ACQ) begin
                        // Locking on the last allowed window beats the timeout.
                        if (w_in && r_good == GOOD_LAST) begin
                            r_state <= S_LOCK;
                            r_ok    <= 1'b1;
                            r_good  <= '0;
                            r_acq   <= '0;
                            r_fail  <= '0;
                        end else begin
                            r_good <= w_in ? r_good + 1'b1 : '0;
                            if (r_acq == ACQ_LAST) begin
                                r_state <= S_FAULT;
                                r_fault <= 1'b1;
                                r_code  <= 2'b11;
                            end else begin
                                r_acq <= r_acq + 1'b1;
                            end
                        end
                    end else if (w_tc) begin
                        if (w_in) begin
                            r_fail <= '0;
                        end else if (r_fail == FAIL_LAST) begin
                            r_state <= S_FAULT;
                            r_ok    <= 1'b0;
                            r_fault <= 1'b1;
                            r_code  <= w_code;
                            r_fail  <= '0;
                        end else begin
                            r_fail <= r_fail + 1'b1;
                        end
                    end
                end
                S_FAULT: if (w_clr) begin
                    r_state <= S_ACQ;
                    r_fault <= 1'b0;
                    r_code  <= 2'b00;
                    r_win   <= '0;
                    r_edge  <= '0;
                    r_good  <= '0;
                    r_fail  <= '0;
                    r_acq   <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.clk_ok_o     = r_ok;
    assign bus.clk_fault_o  = r_fault;
    assign bus.fault_code_o = r_code;
    assign bus.edge_cnt_o   = r_cnt;
    assign bus.cnt_valid_o  = r_valid;
endmodule

// File: tb/tb_safe_clk_freq_monitor.sv
// Scoreboard bench for safe_clk_freq_monitor: per-window expectations are queued by the
// stimulus and checked by a monitor on every cnt_valid_o pulse.
module tb_safe_clk_freq_monitor;
    localparam int WIN = 1024;

    logic clk_main_i     = 1'b0;
    logic rst_n_main_i   = 1'b0;
    logic clk_safety_i   = 1'b0;
    logic rst_n_safety_i = 1'b0;

    safe_clk_freq_monitor_if #(.CNT_W(16)) bus ();

    safe_clk_freq_monitor dut (
        .clk_main_i     (clk_main_i),
        .rst_n_main_i   (rst_n_main_i),
        .clk_safety_i   (clk_safety_i),
        .rst_n_safety_i (rst_n_safety_i),
        .bus            (bus)
    );

    always #5 clk_main_i = ~clk_main_i;

    // Safety clock: gen_n pulses per WIN main cycles, evenly spread, each half a main cycle wide.
    int gen_n   = 256;
    int gen_acc = 0;
    always @(negedge clk_main_i) begin
        gen_acc += gen_n;
        if (gen_acc >= WIN) begin
            gen_acc -= WIN;
            clk_safety_i = 1'b1;
        end
    end
    always @(posedge clk_main_i) clk_safety_i = 1'b0;

    typedef struct {
        int         lo;
        int         hi;
        logic       ok;
        logic       flt;
        logic [1:0] code;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   win_idx = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk_main_i) begin : monitor
        exp_t e;
        if (bus.cnt_valid_o && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            win_idx++;
            checks++;
            if (int'(bus.edge_cnt_o) < e.lo || int'(bus.edge_cnt_o) > e.hi) begin
                errors++;
                $display("FAIL win%0d edge_cnt: got %0d expected %0d..%0d",
                         win_idx, bus.edge_cnt_o, e.lo, e.hi);
            end
            chk($sformatf("win%0d clk_ok", win_idx), int'(bus.clk_ok_o), int'(e.ok));
            chk($sformatf("win%0d clk_fault", win_idx), int'(bus.clk_fault_o), int'(e.flt));
            chk($sformatf("win%0d fault_code", win_idx), int'(bus.fault_code_o), int'(e.code));
        end
    end

    task automatic set_rate(input int n);
        gen_n   = n;
        gen_acc = 0;
    endtask

    // Queue one window's expectation and wait (bounded) for the window to complete.
    task automatic win(input int lo, input int hi, input logic ok, input logic flt,
                       input logic [1:0] code);
        exp_t e;
        int   n;
        e = '{lo, hi, ok, flt, code};
        sb_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk_main_i);
            n++;
        end while (!bus.cnt_valid_o && n < WIN + 80);
        if (!bus.cnt_valid_o) begin
            errors++;
            checks++;
            $display("FAIL win_timeout: got no cnt_valid_o within %0d cycles expected a pulse", n);
            sb_q.delete();
        end
    endtask

    task automatic clr_pulse();
        bus.fault_clr_i = 1'b1;
        @(negedge clk_main_i);
        bus.fault_clr_i = 1'b0;
    endtask

    task automatic relock();
        repeat (3) win(256, 256, 1'b0, 1'b0, 2'b00);
        win(256, 256, 1'b1, 1'b0, 2'b00);
    endtask

    initial begin
        int nv;
        bus.enable_i    = 1'b0;
        bus.fault_clr_i = 1'b0;
`ifdef SAFE_CLK_MON_SELFTEST_EN
        bus.st_force_i  = 2'b00;
`endif
        repeat (3) @(negedge clk_main_i);
        chk("rst clk_ok", int'(bus.clk_ok_o), 0);
        chk("rst clk_fault", int'(bus.clk_fault_o), 0);
        chk("rst fault_code", int'(bus.fault_code_o), 0);
        chk("rst edge_cnt", int'(bus.edge_cnt_o), 0);
        chk("rst cnt_valid", int'(bus.cnt_valid_o), 0);
        rst_n_safety_i = 1'b1;
        rst_n_main_i   = 1'b1;
        repeat (20) @(negedge clk_main_i);
        chk("idle clk_ok", int'(bus.clk_ok_o), 0);

        // Acquire and lock at 256 per window
        bus.enable_i = 1'b1;
        relock();
        win(256, 256, 1'b1, 1'b0, 2'b00);

        // Safety clock stops: first window may catch one in-flight toggle
        set_rate(0);
        win(0, 1, 1'b1, 1'b0, 2'b00);
        win(0, 0, 1'b0, 1'b1, 2'b11);
        win(0, 0, 1'b0, 1'b1, 2'b11);
        set_rate(256);
        repeat (10) @(negedge clk_main_i);
        chk("stop sticky fault", int'(bus.clk_fault_o), 1);
        clr_pulse();
        chk("clr1 clk_fault", int'(bus.clk_fault_o), 0);
        chk("clr1 fault_code", int'(bus.fault_code_o), 0);
        relock();

        // Halved safety frequency
        set_rate(128);
        win(126, 130, 1'b1, 1'b0, 2'b00);
        win(128, 128, 1'b0, 1'b1, 2'b01);
        set_rate(256);
        repeat (10) @(negedge clk_main_i);
        clr_pulse();
        chk("clr2 clk_ok", int'(bus.clk_ok_o), 0);
        relock();

        // One fast window is forgiven, two in a row fault
        set_rate(300);
        win(297, 302, 1'b1, 1'b0, 2'b00);
        set_rate(256);
        win(254, 258, 1'b1, 1'b0, 2'b00);
        set_rate(300);
        win(297, 302, 1'b1, 1'b0, 2'b00);
        win(300, 300, 1'b0, 1'b1, 2'b10);

        // Acquire timeout at 200 per window
        set_rate(200);
        repeat (10) @(negedge clk_main_i);
        clr_pulse();
        repeat (15) win(200, 200, 1'b0, 1'b0, 2'b00);
        win(200, 200, 1'b0, 1'b1, 2'b11);
        bus.enable_i = 1'b0;
        repeat (5) @(negedge clk_main_i);
        chk("dis fault clk_fault", int'(bus.clk_fault_o), 1);
        chk("dis fault code", int'(bus.fault_code_o), 3);
        clr_pulse();
        chk("clr while disabled", int'(bus.clk_fault_o), 1);
        win(200, 200, 1'b0, 1'b1, 2'b11);

        // Async reset in the middle of a window
        repeat (300) @(negedge clk_main_i);
        #2 rst_n_main_i = 1'b0;
        #1;
        chk("midrst clk_fault", int'(bus.clk_fault_o), 0);
        chk("midrst fault_code", int'(bus.fault_code_o), 0);
        chk("midrst edge_cnt", int'(bus.edge_cnt_o), 0);
        chk("midrst clk_ok", int'(bus.clk_ok_o), 0);
        set_rate(256);
        @(negedge clk_main_i);
        rst_n_main_i = 1'b1;
        repeat (10) @(negedge clk_main_i);

        // Lock, then disable: back to IDLE, no more windows
        bus.enable_i = 1'b1;
        relock();
        bus.enable_i = 1'b0;
        @(negedge clk_main_i);
        chk("disable clk_ok", int'(bus.clk_ok_o), 0);
        nv = 0;
        repeat (WIN + 80) begin
            @(negedge clk_main_i);
            if (bus.cnt_valid_o) nv++;
        end
        chk("idle cnt_valid pulses", nv, 0);

`ifdef SAFE_CLK_MON_SELFTEST_EN
        bus.enable_i = 1'b1;
        relock();
        bus.st_force_i = 2'b01;
        win(0, 0, 1'b1, 1'b0, 2'b00);
        win(0, 0, 1'b0, 1'b1, 2'b11);
        bus.st_force_i = 2'b00;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
